// File: rtl/mem_lsu.sv
// mem_lsu -- MEM-stage load/store unit.
//
// Takes the EX/MEM register outputs, runs one req/ack bus transaction per load
// or store, stalls the front of the pipeline until the access completes, and
// hands aligned/extended load data (or the ALU result) to the MEM/WB register.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   mem_aluop                       operation from EX/MEM
//   mem_mem_addr                    effective byte address
//   mem_store_data                  store source value
//   mem_reg_write_data/addr/en      ALU result and destination from EX/MEM
//   hold_from_wb                    downstream stall; keeps a finished access in DONE
//   data_req/we/wstrb/addr/wdata    bus request side
//   data_ack, data_rdata            bus completion and read word
//   stall_req                       stall EX/MEM and earlier stages
//   ale                             address-misalign exception flag
//   wb_reg_write_data/addr/en       to MEM/WB register
//
// Build option
//   MEM_LSU_ALIGN_CHECK_EN  defined: misaligned halfword/word ops raise ale and
//                           are not issued. Undefined: ale is 0 and misaligned
//                           ops access the aligned containing unit.

`ifndef ALUOpWidth
`define ALUOpWidth 8
`endif
`ifndef ALU_LDB
`define ALU_LDB  8'h20
`define ALU_LDH  8'h21
`define ALU_LDW  8'h22
`define ALU_LDBU 8'h23
`define ALU_LDHU 8'h24
`define ALU_STB  8'h28
`define ALU_STH  8'h29
`define ALU_STW  8'h2A
`endif

module mem_lsu (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`ALUOpWidth-1:0] mem_aluop,
  input  logic [31:0]            mem_mem_addr,
  input  logic [31:0]            mem_store_data,
  input  logic [31:0]            mem_reg_write_data,
  input  logic [4:0]             mem_reg_write_addr,
  input  logic                   mem_reg_write_en,
  input  logic                   hold_from_wb,
  output logic                   data_req,
  output logic                   data_we,
  output logic [3:0]             data_wstrb,
  output logic [31:0]            data_addr,
  output logic [31:0]            data_wdata,
  input  logic                   data_ack,
  input  logic [31:0]            data_rdata,
  output logic                   stall_req,
  output logic                   ale,
  output logic [31:0]            wb_reg_write_data,
  output logic [4:0]             wb_reg_write_addr,
  output logic                   wb_reg_write_en
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t      state, state_nxt;

  logic        is_ld, is_st, is_mem, ld_sext, misal, go;
  logic [1:0]  sz, off;

  logic        req_ld_p1, req_sext_p1;
  logic [1:0]  req_sz_p1, req_off_p1;
  logic [31:0] ld_buf_p2;

  function automatic logic [3:0] fmt_wstrb(input logic [1:0] s, input logic [1:0] o);
    case (s)
      SZ_B:    return 4'b0001 << o;
      SZ_H:    return 4'b0011 << o;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] fmt_wdata(input logic [1:0] s, input logic [31:0] d);
    case (s)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ext_load(input logic [1:0] s, input logic sx,
                                           input logic [1:0] o, input logic [31:0] rd);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = rd >> {o, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (s)
      SZ_B:    r = sx ? 32'(b) : {24'b0, sh[7:0]};
      SZ_H:    r = sx ? 32'(h) : {16'b0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  always_comb begin
    is_ld   = 1'b0;
    is_st   = 1'b0;
    ld_sext = 1'b0;
    sz      = SZ_W;
    case (mem_aluop)
      `ALU_LDB:  begin is_ld = 1'b1; sz = SZ_B; ld_sext = 1'b1; end
      `ALU_LDH:  begin is_ld = 1'b1; sz = SZ_H; ld_sext = 1'b1; end
      `ALU_LDW:  begin is_ld = 1'b1; sz = SZ_W; end
      `ALU_LDBU: begin is_ld = 1'b1; sz = SZ_B; end
      `ALU_LDHU: begin is_ld = 1'b1; sz = SZ_H; end
      `ALU_STB:  begin is_st = 1'b1; sz = SZ_B; end
      `ALU_STH:  begin is_st = 1'b1; sz = SZ_H; end
      `ALU_STW:  begin is_st = 1'b1; sz = SZ_W; end
      default:   ;
    endcase
  end

  assign is_mem = is_ld | is_st;

  // Low address bits the access size cannot use are dropped, so a misaligned
  // access (when not trapped) lands on its aligned containing unit.
  always_comb begin
    case (sz)
      SZ_B:    off = mem_mem_addr[1:0];
      SZ_H:    off = {mem_mem_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

`ifdef MEM_LSU_ALIGN_CHECK_EN
  assign misal = is_mem && (((sz == SZ_H) && mem_mem_addr[0]) ||
                            ((sz == SZ_W) && (mem_mem_addr[1:0] != 2'b00)));
`else
  assign misal = 1'b0;
`endif

  assign go  = is_mem && !misal;
  assign ale = (state == IDLE) && misal;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = REQ;
      REQ:     if (data_ack) state_nxt = DONE;
      DONE:    if (!hold_from_wb) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture: bus fields frozen for the whole REQ state
  always_ff @(posedge clk) begin
    if (rst) begin
      data_we     <= 1'b0;
      data_wstrb  <= 4'b0;
      data_addr   <= 32'b0;
      data_wdata  <= 32'b0;
      req_ld_p1   <= 1'b0;
      req_sext_p1 <= 1'b0;
      req_sz_p1   <= 2'b0;
      req_off_p1  <= 2'b0;
      ld_buf_p2   <= 32'b0;
    end else begin
      if ((state == IDLE) && go) begin
        data_we     <= is_st;
        data_wstrb  <= is_st ? fmt_wstrb(sz, off) : 4'b0000;
        data_addr   <= {mem_mem_addr[31:2], 2'b00};
        data_wdata  <= fmt_wdata(sz, mem_store_data);
        req_ld_p1   <= is_ld;
        req_sext_p1 <= ld_sext;
        req_sz_p1   <= sz;
        req_off_p1  <= off;
      end
      // Load completion: extracted value buffered for DONE
      if ((state == REQ) && data_ack)
        ld_buf_p2 <= ext_load(req_sz_p1, req_sext_p1, req_off_p1, data_rdata);
    end
  end

  // Request drops in the reset cycle itself so the bus never sees a stale req.
  assign data_req = (state == REQ) && !rst;

  always_comb begin
    wb_reg_write_data = mem_reg_write_data;
    wb_reg_write_addr = mem_reg_write_addr;
    wb_reg_write_en   = mem_reg_write_en;
    stall_req         = 1'b0;
    case (state)
      IDLE: begin
        if (is_mem) begin
          wb_reg_write_en = 1'b0;
          stall_req       = go;
        end
      end
      REQ: begin
        wb_reg_write_en = 1'b0;
        stall_req       = 1'b1;
      end
      DONE: begin
        if (req_ld_p1) wb_reg_write_data = ld_buf_p2;
        else           wb_reg_write_en   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_lsu.sv
`timescale 1ns/1ps

`ifndef ALUOpWidth
`define ALUOpWidth 8
`endif
`ifndef ALU_LDB
`define ALU_LDB  8'h20
`define ALU_LDH  8'h21
`define ALU_LDW  8'h22
`define ALU_LDBU 8'h23
`define ALU_LDHU 8'h24
`define ALU_STB  8'h28
`define ALU_STH  8'h29
`define ALU_STW  8'h2A
`endif

module tb_mem_lsu;

  localparam logic [`ALUOpWidth-1:0] OP_ADD = 8'h01;
  localparam logic [`ALUOpWidth-1:0] OP_NOP = 8'h00;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [`ALUOpWidth-1:0] mem_aluop;
  logic [31:0]            mem_mem_addr, mem_store_data, mem_reg_write_data;
  logic [4:0]             mem_reg_write_addr;
  logic                   mem_reg_write_en, hold_from_wb;
  logic                   data_req, data_we, data_ack, stall_req, ale;
  logic [3:0]             data_wstrb;
  logic [31:0]            data_addr, data_wdata, data_rdata;
  logic [31:0]            wb_reg_write_data;
  logic [4:0]             wb_reg_write_addr;
  logic                   wb_reg_write_en;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk(clk), .rst(rst),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_store_data(mem_store_data),
    .mem_reg_write_data(mem_reg_write_data), .mem_reg_write_addr(mem_reg_write_addr),
    .mem_reg_write_en(mem_reg_write_en), .hold_from_wb(hold_from_wb),
    .data_req(data_req), .data_we(data_we), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_ack(data_ack), .data_rdata(data_rdata),
    .stall_req(stall_req), .ale(ale),
    .wb_reg_write_data(wb_reg_write_data), .wb_reg_write_addr(wb_reg_write_addr),
    .wb_reg_write_en(wb_reg_write_en)
  );

  typedef struct {
    string                  name;
    logic [`ALUOpWidth-1:0] op;
    logic [31:0]            addr;
    logic [31:0]            sdata;
    logic [31:0]            rdata;
    int                     dly;
    logic [31:0]            exp_data;
    logic                   exp_en;
    logic                   exp_we;
    logic [3:0]             exp_wstrb;
    logic [31:0]            exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic [4:0]  addr;
  } wb_t;

  wb_t  sb[$];
  vec_t vt[9];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_nop();
    mem_aluop          = OP_NOP;
    mem_mem_addr       = 32'h0;
    mem_store_data     = 32'h0;
    mem_reg_write_data = 32'h0;
    mem_reg_write_addr = 5'd0;
    mem_reg_write_en   = 1'b0;
    data_ack           = 1'b0;
    hold_from_wb       = 1'b0;
  endtask

  // One full memory transaction: IDLE cycle, dly+1 REQ cycles, DONE, back to IDLE.
  task automatic run_mem(input vec_t v, input logic [4:0] rd);
    int  stalls;
    int  reqs;
    wb_t e;
    mem_aluop          = v.op;
    mem_mem_addr       = v.addr;
    mem_store_data     = v.sdata;
    mem_reg_write_data = 32'h0BAD_0000;
    mem_reg_write_addr = rd;
    mem_reg_write_en   = 1'b1;
    data_ack           = 1'b0;
    hold_from_wb       = 1'b0;
    #1;
    chk({v.name, " c0 stall"}, 32'(stall_req), 32'd1);
    chk({v.name, " c0 req"}, 32'(data_req), 32'd0);
    chk({v.name, " c0 wb_en"}, 32'(wb_reg_write_en), 32'd0);
    e.data = v.exp_data;
    e.en   = v.exp_en;
    e.addr = rd;
    sb.push_back(e);
    stalls = 1;
    reqs   = 0;
    tick();
    for (int k = 0; k <= v.dly; k++) begin
      data_ack   = (k == v.dly);
      data_rdata = (k == v.dly) ? v.rdata : 32'hA5A5_A5A5;
      #1;
      if (data_req)  reqs++;
      if (stall_req) stalls++;
      chk({v.name, " addr"}, data_addr, {v.addr[31:2], 2'b00});
      chk({v.name, " wstrb"}, 32'(data_wstrb), 32'(v.exp_wstrb));
      chk({v.name, " we"}, 32'(data_we), 32'(v.exp_we));
      if (v.exp_we) chk({v.name, " wdata"}, data_wdata, v.exp_wdata);
      tick();
    end
    data_ack   = 1'b0;
    data_rdata = 32'h5A5A_5A5A;
    #1;
    chk({v.name, " done stall"}, 32'(stall_req), 32'd0);
    chk({v.name, " done req"}, 32'(data_req), 32'd0);
    chk({v.name, " stall cycles"}, 32'(stalls), 32'(v.dly + 2));
    chk({v.name, " req cycles"}, 32'(reqs), 32'(v.dly + 1));
    if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL %s scoreboard: got empty queue expected entry", v.name);
    end else begin
      e = sb.pop_front();
      if (e.en) chk({v.name, " wb_data"}, wb_reg_write_data, e.data);
      chk({v.name, " wb_en"}, 32'(wb_reg_write_en), 32'(e.en));
      chk({v.name, " wb_addr"}, 32'(wb_reg_write_addr), 32'(e.addr));
    end
    tick();
    drive_nop();
  endtask

  initial begin
    vt[0] = '{"ldb",  `ALU_LDB,  32'h0000_1003, 32'h0,         32'h80FF_0000, 0, 32'hFFFF_FF80, 1'b1, 1'b0, 4'b0000, 32'h0};
    vt[1] = '{"sth",  `ALU_STH,  32'h0000_2002, 32'h0000_ABCD, 32'h0,         0, 32'h0,         1'b0, 1'b1, 4'b1100, 32'hABCD_ABCD};
    vt[2] = '{"ldw4", `ALU_LDW,  32'h0000_3000, 32'h0,         32'hDEAD_BEEF, 4, 32'hDEAD_BEEF, 1'b1, 1'b0, 4'b0000, 32'h0};
    vt[3] = '{"ldh",  `ALU_LDH,  32'h0000_1002, 32'h0,         32'h8001_1234, 1, 32'hFFFF_8001, 1'b1, 1'b0, 4'b0000, 32'h0};
    vt[4] = '{"ldbu", `ALU_LDBU, 32'h0000_1001, 32'h0,         32'h0000_9A00, 0, 32'h0000_009A, 1'b1, 1'b0, 4'b0000, 32'h0};
    vt[5] = '{"stb",  `ALU_STB,  32'h0000_4001, 32'h1234_56C3, 32'h0,         0, 32'h0,         1'b0, 1'b1, 4'b0010, 32'hC3C3_C3C3};
    vt[6] = '{"stw",  `ALU_STW,  32'h0000_4000, 32'hCAFE_F00D, 32'h0,         2, 32'h0,         1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D};
    vt[7] = '{"ldhu", `ALU_LDHU, 32'h0000_1000, 32'h0,         32'h1234_F00F, 2, 32'h0000_F00F, 1'b1, 1'b0, 4'b0000, 32'h0};
    vt[8] = '{"ldb+", `ALU_LDB,  32'h0000_1000, 32'h0,         32'h0000_007F, 0, 32'h0000_007F, 1'b1, 1'b0, 4'b0000, 32'h0};

    drive_nop();
    data_rdata = 32'h0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst data_req", 32'(data_req), 32'd0);
    chk("rst data_we", 32'(data_we), 32'd0);
    chk("rst wstrb", 32'(data_wstrb), 32'd0);
    chk("rst addr", data_addr, 32'd0);
    chk("rst wdata", data_wdata, 32'd0);
    chk("rst stall", 32'(stall_req), 32'd0);
    chk("rst ale", 32'(ale), 32'd0);
    chk("rst wb_data", wb_reg_write_data, 32'd0);
    chk("rst wb_en", 32'(wb_reg_write_en), 32'd0);
    rst = 1'b0;

    // ALU pass-through
    mem_aluop          = OP_ADD;
    mem_reg_write_data = 32'h0000_1234;
    mem_reg_write_addr = 5'd5;
    mem_reg_write_en   = 1'b1;
    #1;
    chk("alu wb_data", wb_reg_write_data, 32'h0000_1234);
    chk("alu wb_addr", 32'(wb_reg_write_addr), 32'd5);
    chk("alu wb_en", 32'(wb_reg_write_en), 32'd1);
    chk("alu stall", 32'(stall_req), 32'd0);
    tick();
    drive_nop();

    for (int i = 0; i < 9; i++) run_mem(vt[i], 5'(i + 1));

    // Misaligned halfword load
`ifdef MEM_LSU_ALIGN_CHECK_EN
    mem_aluop        = `ALU_LDHU;
    mem_mem_addr     = 32'h0000_1001;
    mem_reg_write_en = 1'b1;
    #1;
    chk("misal ale", 32'(ale), 32'd1);
    chk("misal stall", 32'(stall_req), 32'd0);
    chk("misal wb_en", 32'(wb_reg_write_en), 32'd0);
    data_ack = 1'b1;
    tick();
    chk("misal req", 32'(data_req), 32'd0);
    chk("misal stays idle", 32'(stall_req), 32'd0);
    drive_nop();
    #1;
    chk("misal ale clear", 32'(ale), 32'd0);
`else
    begin
      vec_t m;
      m = '{"misal", `ALU_LDHU, 32'h0000_1001, 32'h0, 32'h5555_8765, 0, 32'h0000_8765, 1'b1, 1'b0, 4'b0000, 32'h0};
      run_mem(m, 5'd20);
      chk("misal ale", 32'(ale), 32'd0);
    end
`endif

    // Reset while in REQ
    mem_aluop        = `ALU_LDW;
    mem_mem_addr     = 32'h0000_5000;
    mem_reg_write_en = 1'b1;
    tick();
    chk("rstreq req before", 32'(data_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq req same cycle", 32'(data_req), 32'd0);
    tick();
    rst = 1'b0;
    drive_nop();
    #1;
    chk("rstreq req after", 32'(data_req), 32'd0);
    data_ack   = 1'b1;
    data_rdata = 32'h1111_2222;
    tick();
    data_ack = 1'b0;
    #1;
    chk("rstreq late ack req", 32'(data_req), 32'd0);
    chk("rstreq late ack stall", 32'(stall_req), 32'd0);
    chk("rstreq late ack wb_en", 32'(wb_reg_write_en), 32'd0);

    // hold_from_wb in DONE
    mem_aluop          = `ALU_LDW;
    mem_mem_addr       = 32'h0000_6000;
    mem_reg_write_addr = 5'd9;
    mem_reg_write_en   = 1'b1;
    tick();
    data_ack   = 1'b1;
    data_rdata = 32'h0BAD_F00D;
    tick();
    data_ack     = 1'b0;
    data_rdata   = 32'h0;
    hold_from_wb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold req", 32'(data_req), 32'd0);
      chk("hold wb_data", wb_reg_write_data, 32'h0BAD_F00D);
      chk("hold wb_en", 32'(wb_reg_write_en), 32'd1);
      chk("hold stall", 32'(stall_req), 32'd0);
      tick();
    end
    hold_from_wb = 1'b0;
    #1;
    chk("release wb_data", wb_reg_write_data, 32'h0BAD_F00D);
    tick();
    drive_nop();
    #1;
    chk("release idle req", 32'(data_req), 32'd0);
    chk("release idle wb_en", 32'(wb_reg_write_en), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
